// File: rtl/bin_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: state encodings and
// the digit code driven on every BCD digit when the divider reports an error.
package bin_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ERR_DIGIT = 4'hF;

endpackage

// File: rtl/bin_bcd_add3.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Wraps modulo 16; only values 0..9 occur in a correct conversion.
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// Handshake: strt is sampled only while idle (busy=0); a strt with err_in=1
// skips the conversion and returns all-F digits with err=1. rdy pulses for
// one cycle when bcd/err are updated; bcd/err hold until the next result.
// A strt presented during the rdy cycle is accepted, since the FSM is idle.
module bin_bcd
    import bin_bcd_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   bin,
    input  logic           err_in,
    input  logic           strt,
    output logic [4*D-1:0] bcd,
    output logic           err,
    output logic           busy,
    output logic           rdy,
    output logic [1:0]     state_dbg
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    shreg;
    logic [4*D-1:0]  scratch;
    logic [4*D-1:0]  scratch_adj;
    logic [CW-1:0]   cnt;
    logic            err_path;

    // One correction cell per BCD digit of the scratch register.
    genvar g;
    generate
        for (g = 0; g < D; g++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (scratch[4*g +: 4]),
                .dout (scratch_adj[4*g +: 4])
            );
        end
    endgenerate

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: N shift cycles, then one cycle to publish the result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (strt) begin
                    state_nxt = err_in ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_SHIFT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture, shift-and-correct, and publish the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            err_path <= 1'b0;
            bcd      <= '0;
            err      <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (strt) begin
                        err_path <= err_in;
                        if (!err_in) begin
                            shreg   <= bin;
                            scratch <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= {scratch_adj[4*D-2:0], shreg, 1'b0};
                    cnt              <= cnt + 1'b1;
                end
                DONE: begin
                    bcd <= err_path ? {D{ERR_DIGIT}} : scratch;
                    err <= err_path;
                    rdy <= 1'b1;
                end
                default: begin
                    rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bcd.sv
// Self-checking bench for bin_bcd: directed scenarios plus randomized traffic,
// all checked each cycle against a timeline model built from decimal arithmetic.
module tb_bin_bcd;

  localparam int N = 8;
  localparam int D = 3;

  logic           clk;
  logic           rst;
  logic [N-1:0]   bin;
  logic           err_in;
  logic           strt;
  logic [4*D-1:0] bcd;
  logic           err;
  logic           busy;
  logic           rdy;
  logic [1:0]     state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 0;

  // Model state: cycles left until the pending result appears, queued results,
  // and the published outputs.
  int             m_left = 0;
  logic [4*D:0]   exp_q[$];
  logic [4*D-1:0] m_bcd = '0;
  logic           m_err = 1'b0;
  logic           m_rdy = 1'b0;

  bin_bcd #(.N(N), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin       (bin),
    .err_in    (err_in),
    .strt      (strt),
    .bcd       (bcd),
    .err       (err),
    .busy      (busy),
    .rdy       (rdy),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of v, units in the low nibble.
  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a conversion is visible N+1 edges after acceptance,
  // an error request 1 edge after; requests while busy are dropped.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0;
      m_bcd  = '0;
      m_err  = 1'b0;
      m_rdy  = 1'b0;
      exp_q.delete();
    end else begin
      m_rdy = 1'b0;
      if (m_left == 0) begin
        if (strt === 1'b1) begin
          if (err_in) begin
            exp_q.push_back({1'b1, {D{4'hF}}});
            m_left = 1;
          end else begin
            exp_q.push_back({1'b0, to_bcd(int'(bin))});
            m_left = N + 1;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0 && exp_q.size() > 0) begin
          {m_err, m_bcd} = exp_q.pop_front();
          m_rdy = 1'b1;
        end
      end
    end
  end

  // Compare process: every outputs on every falling edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("bcd",  32'(bcd),  32'(m_bcd));
      chk("err",  32'(err),  32'(m_err));
      chk("rdy",  32'(rdy),  32'(m_rdy));
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("idle_state", 32'(state_dbg == 2'd0), 32'(m_left == 0));
    end
  end

  // Driver: one request from posedge+1; optional second strt mid-shift.
  task automatic run(input logic [N-1:0] b, input logic e, input int mid,
                     input logic [4*D-1:0] xb, input logic xe, input string name);
    int edges;
    int busy_n;
    edges  = 0;
    busy_n = 0;
    bin    = b;
    err_in = e;
    strt   = 1'b1;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_n++;
      if (edges == 1) begin
        strt   = 1'b0;
        bin    = N'($urandom);
        err_in = 1'($urandom_range(0, 1));
      end
      if (mid >= 0 && edges == 4) begin
        strt = 1'b1;
        bin  = N'(mid);
      end
      if (edges == 5) strt = 1'b0;
    end while (!rdy && edges < 40);
    chk({name, "_edges"}, 32'(edges), e ? 32'd2 : 32'(N + 2));
    chk({name, "_busy_cycles"}, 32'(busy_n), e ? 32'd1 : 32'(N + 1));
    chk({name, "_bcd"}, 32'(bcd), 32'(xb));
    chk({name, "_err"}, 32'(err), 32'(xe));
  endtask

  initial begin
    rst    = 1'b1;
    strt   = 1'b0;
    bin    = '0;
    err_in = 1'b0;
    #1 rst = 1'b0;

    // Pin the model's decimal conversion with hand values.
    chk("model_255", 32'(to_bcd(255)), 32'h255);
    chk("model_100", 32'(to_bcd(100)), 32'h100);
    chk("model_9",   32'(to_bcd(9)),   32'h009);
    chk("model_0",   32'(to_bcd(0)),   32'h000);

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bcd",  32'(bcd),  32'h000);
    chk("reset_err",  32'(err),  32'd0);
    chk("reset_rdy",  32'(rdy),  32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    run(8'd255, 1'b0, -1, 12'h255, 1'b0, "max");
    run(8'd0,   1'b0, -1, 12'h000, 1'b0, "b2b_0");
    run(8'd100, 1'b0, -1, 12'h100, 1'b0, "b2b_100");
    run(8'd9,   1'b0, -1, 12'h009, 1'b0, "b2b_9");
    run(8'd37,  1'b1, -1, 12'hFFF, 1'b1, "errpath");
    run(8'd37,  1'b0, -1, 12'h037, 1'b0, "after_err");
    run(8'd123, 1'b0, 77, 12'h123, 1'b0, "mid_strt");
    repeat (12) begin
      @(posedge clk);
      #1 chk("no_second_rdy", 32'(rdy), 32'd0);
    end

    // Reset after the fourth shift of 200.
    bin    = 8'd200;
    err_in = 1'b0;
    strt   = 1'b1;
    @(posedge clk);
    #1 strt = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_bcd",  32'(bcd),  32'h000);
    chk("abort_err",  32'(err),  32'd0);
    chk("abort_rdy",  32'(rdy),  32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1 chk("abort_no_rdy", 32'(rdy), 32'd0);
    end
    run(8'd200, 1'b0, -1, 12'h200, 1'b0, "after_abort");

    // Random traffic: strt often asserted while busy and during rdy.
    repeat (3000) begin
      bin    = N'($urandom);
      err_in = ($urandom_range(0, 7) == 0);
      strt   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #2 rst = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    strt = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_bcd.md
BIN_BCD -- requirements
Module: bin_bcd

Interface
REQ-001 Parameter N, default 8: width of the binary input.
REQ-002 Parameter D, default 3: number of BCD output digits; the configuration SHALL satisfy 10^D > 2^N-1.
REQ-003 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 bin  input  N  unsigned binary value to convert (quotient or remainder from the divider).
REQ-006 err_in  input  1  divider error flag, sampled together with strt.
REQ-007 strt  input  1  start request, sampled only in IDLE; driven by the divider's rdy pulse.
REQ-008 bcd  output  4*D  packed BCD result; digit 0 is bcd[3:0] (units).
REQ-009 err  output  1  registered error flag accompanying bcd.
REQ-010 busy  output  1  high while a conversion is in progress (state != IDLE).
REQ-011 rdy  output  1  one-cycle pulse marking that bcd/err were updated.

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE, with busy = (state != IDLE).
REQ-013 IDLE with strt=1 and err_in=0 at an edge (E0): capture bin into an N-bit shift register, clear the 4*D-bit scratch register to 0, clear the shift counter, and move to SHIFT.
REQ-014 IDLE with strt=1 and err_in=1: no capture; move directly to DONE with the error path selected.
REQ-015 SHIFT, each edge: every scratch digit >= 5 gets +3 (mod 16); then {scratch, shreg} shifts left by 1 and the counter increments.
REQ-016 SHIFT SHALL last exactly N edges (E1..EN); the edge performing the N-th shift also moves the state to DONE.
REQ-017 DONE, next edge (EN+1): load bcd from scratch (or all digits = 4'hF on the error path), load err (0 or 1), set rdy=1, and return to IDLE.
REQ-018 rdy SHALL be high for exactly one cycle following EN+1 (N+2 edges after the strt edge; 2 edges on the error path), and low otherwise.
REQ-019 bcd and err SHALL hold their values until the next DONE-exit edge.
REQ-020 strt SHALL be ignored while busy=1; no queuing.
REQ-021 A strt arriving in the same cycle that rdy is high SHALL be accepted (state is IDLE).
REQ-022 bin and err_in are don't-care except at the accepting edge; later changes SHALL NOT affect the result.
REQ-023 The counter SHALL be ceil(log2(N+1)) bits wide; the +3 correction is applied on 4-bit digits, and no other arithmetic is performed.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, bcd=0, err=0, rdy=0, busy=0, and clear the shift, scratch and counter registers.
REQ-025 Reset during SHIFT or DONE SHALL abort the conversion, with no rdy pulse and no bcd update; operation resumes from IDLE on the first edge after rst returns to 1.

Structure
REQ-026 A shared package SHALL hold the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the error digit code 4'hF.
REQ-027 A combinational sub-module bcd_add3 (4-bit in/out, +3 if >= 5) SHALL be instantiated D times in generate form; the rest is a single FSM-plus-datapath module.

Verification
REQ-028 rst=0 then released, no strt -> bcd=12'h000, err=0, rdy=0, busy=0.
REQ-029 bin=8'd255, strt pulse -> busy for 9 cycles, rdy pulse exactly 10 edges after the strt edge, bcd=12'h255, err=0.
REQ-030 bin=8'd0, then 8'd100, then 8'd9, back-to-back (strt on rdy) -> bcd=12'h000, 12'h100, 12'h009, each with one rdy pulse.
REQ-031 err_in=1 with strt, bin=8'd37 -> rdy 2 edges later, bcd=12'hFFF, err=1; a following bin=8'd37 with err_in=0 -> bcd=12'h037, err=0.
REQ-032 strt reasserted mid-SHIFT with a different bin -> ignored; the result equals the first value, single rdy.
REQ-033 rst pulsed low at shift 4 of bin=8'd200 -> outputs zero immediately, no rdy; a subsequent strt with 8'd200 -> bcd=12'h200.
